// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern-detect controller.
// Contents: FSM state encoding, datapath widths, default pattern, fill helper.
package seq_det_pkg;

    localparam int unsigned PAT_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned FILL_W = 3;
    localparam int unsigned RES_W  = 4;

    localparam logic [PAT_W-1:0] DEFAULT_PATTERN = 4'b0101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Fill level saturates once the history holds a full pattern's worth of bits.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] fill);
        return (fill >= FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
    endfunction

endpackage

// File: rtl/seq_det_prog.sv
// Programmable overlapping 4-bit pattern detector with stream-continuous history.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   clear_i           zero history and fill (pattern kept)
//   load_i, pat_i     load a new pattern; also restarts the history
//   bit_valid_i/bit_i one serial bit to append to the history
//   match_c_o         combinational: this bit completes a match
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic             match_c_o
);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  hist_upd;

    // Next history/fill/pattern; a match needs the post-shift fill to reach PAT_W.
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        hist_upd  = {hist_q[PAT_W-2:0], bit_i};
        match_c_o = bit_valid_i && (fill_q >= FILL_W'(PAT_W - 1)) && (hist_upd == pat_q);

        if (load_i) begin
            pat_d  = pat_i;
            hist_d = '0;
            fill_d = '0;
        end else if (bit_valid_i) begin
            hist_d = hist_upd;
            fill_d = fill_inc(fill_q);
        end

        // Clear wins over a same-cycle shift; the match it completes still reports.
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Byte-serialising controller around the programmable pattern detector.
// Accepts a byte, scans it MSB first one bit per cycle, then holds a
// per-byte match count until the consumer takes it.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_data/in_ready    byte input handshake
//   pat_load/pat_data            runtime pattern load (IDLE only)
//   clear                        zero total_count and detector history
//   res_valid/res_count/res_ready per-byte result handshake
//   det_pulse                    one-cycle pulse per match
//   total_count                  saturating running match count
//   busy                         controller not in IDLE
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    input  logic              pat_load,
    input  logic [PAT_W-1:0]  pat_data,
    input  logic              clear,
    output logic              res_valid,
    output logic [RES_W-1:0]  res_count,
    input  logic              res_ready,
    output logic              det_pulse,
    output logic [CNT_W-1:0]  total_count,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RES_W-1:0]  rcnt_q, rcnt_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              in_ready_q, in_ready_d;
    logic              res_valid_q, res_valid_d;
    logic              busy_q, busy_d;
    logic              det_q;

    logic              shift_en_c;
    logic              load_en_c;
    logic              bit_c;
    logic              match_c;

    assign bit_c = data_q[idx_q];

    seq_det_prog #(
        .PATTERN (PATTERN)
    ) u_prog (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .load_i      (load_en_c),
        .pat_i       (pat_data),
        .bit_valid_i (shift_en_c),
        .bit_i       (bit_c),
        .match_c_o   (match_c)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        idx_d      = idx_q;
        rcnt_d     = rcnt_q;
        shift_en_c = 1'b0;
        load_en_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Pattern load and byte accept may coincide; the byte sees the new pattern.
                load_en_c = pat_load;
                if (in_valid) begin
                    data_d  = in_data;
                    idx_d   = IDX_W'(BYTE_W - 1);
                    rcnt_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en_c = 1'b1;
                if (match_c) begin
                    rcnt_d = rcnt_q + RES_W'(1);
                end
                if (idx_q == '0) begin
                    state_d = REPORT;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear beats a same-cycle increment; otherwise saturate at all-ones.
        total_d = total_q;
        if (clear) begin
            total_d = '0;
        end else if (match_c && (total_q != CNT_MAX)) begin
            total_d = total_q + CNT_W'(1);
        end

        in_ready_d  = (state_d == IDLE);
        res_valid_d = (state_d == REPORT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            idx_q       <= '0;
            rcnt_q      <= '0;
            total_q     <= '0;
            det_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            rcnt_q      <= rcnt_d;
            total_q     <= total_d;
            det_q       <= match_c;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign res_valid   = res_valid_q;
    assign res_count   = rcnt_q;
    assign det_pulse   = det_q;
    assign total_count = total_q;
    assign busy        = busy_q;

endmodule
